// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared constants for the multi-cycle RISC-V control path.
// Holds the FSM state encoding, decoded opcodes, datapath select encodings
// and the control-word struct driven by the main control FSM.
package riscv_ctrl_pkg;

  // FSM state encoding (4-bit, legacy-compatible constants)
  localparam logic [3:0] S_RESET    = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_MEMADR   = 4'd3;
  localparam logic [3:0] S_MEMREAD  = 4'd4;
  localparam logic [3:0] S_MEMWB    = 4'd5;
  localparam logic [3:0] S_MEMWRITE = 4'd6;
  localparam logic [3:0] S_EXECR    = 4'd7;
  localparam logic [3:0] S_EXECI    = 4'd8;
  localparam logic [3:0] S_ALUWB    = 4'd9;
  localparam logic [3:0] S_BEQ      = 4'd10;
  localparam logic [3:0] S_JAL      = 4'd11;
  localparam logic [3:0] S_TRAP     = 4'd12;

  // Supported opcodes (INSTR[6:0])
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // ALU operation select
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  // ALU operand A select
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Result mux select
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // Memory address select
  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_ALUOUT = 1'b1;

  // Immediate format select
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Control word produced by the FSM each cycle (IMM_SRC and ILLEGAL live apart)
  typedef struct packed {
    logic       mem_req;
    logic       mem_w;
    logic       pc_w;
    logic       ir_w;
    logic       reg_w;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] alu_op;
  } ctrl_t;

  // True for every opcode the core executes
  function automatic logic is_supported(input logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
           (op == OP_I) || (op == OP_BEQ) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// multi_cycle_ctrl_if: controller <-> datapath/memory signal bundle.
//
// Memory handshake: MEM_REQ acts as valid and MEM_RDY as ready. While
// MEM_REQ is high the controller holds ADR_SRC and MEM_W stable; the access
// completes in the cycle where MEM_REQ and MEM_RDY are both high, and the
// controller moves on at the following edge. MEM_RDY is ignored while
// MEM_REQ is low.
interface multi_cycle_ctrl_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] INSTR;
  logic            ZERO;
  logic            MEM_RDY;
  logic            MEM_REQ;
  logic            MEM_W;
  logic            PC_W;
  logic            IR_W;
  logic            REG_W;
  logic            ADR_SRC;
  logic [1:0]      ALU_SRC_A;
  logic [1:0]      ALU_SRC_B;
  logic [1:0]      RESULT_SRC;
  logic [1:0]      ALU_OP;
  logic [1:0]      IMM_SRC;
  logic            ILLEGAL;

  // Controller side
  modport master (
    input  INSTR, ZERO, MEM_RDY,
    output MEM_REQ, MEM_W, PC_W, IR_W, REG_W, ADR_SRC,
           ALU_SRC_A, ALU_SRC_B, RESULT_SRC, ALU_OP, IMM_SRC, ILLEGAL
  );

  // Datapath / memory side
  modport slave (
    output INSTR, ZERO, MEM_RDY,
    input  MEM_REQ, MEM_W, PC_W, IR_W, REG_W, ADR_SRC,
           ALU_SRC_A, ALU_SRC_B, RESULT_SRC, ALU_OP, IMM_SRC, ILLEGAL
  );
endinterface

// File: rtl/imm_src_dec.sv
// imm_src_dec: opcode -> immediate format select. Pure combinational so it
// can be shared with the single-cycle decoder.
module imm_src_dec
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [1:0] imm_src
);

  // Map each supported opcode to its immediate layout; others default to I
  always_comb begin
    imm_src = IMM_I;
    case (opcode)
      OP_LW:   imm_src = IMM_I;
      OP_I:    imm_src = IMM_I;
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: main control FSM of the multi-cycle RISC-V core.
// Sequences fetch, decode, execute, memory and write-back over the shared
// datapath and stalls in place while memory is not ready.
//
// Build option ILLEGAL_TRAP_EN:
//   defined   - an unsupported opcode parks the FSM in S_TRAP with ILLEGAL
//               held high until reset.
//   undefined - an unsupported opcode is a NOP: back to S_FETCH, ILLEGAL
//               pulses for one cycle.
module multi_cycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter int RST_STATE_CYCLES = 1   // 1..4 cycles in S_RESET after release
) (
  input  logic                CLK,
  input  logic                RST,     // asynchronous, active-low
  multi_cycle_ctrl_if.master  bus,
  output logic [3:0]          state_dbg
);

  localparam logic [2:0] RST_LOAD = 3'(RST_STATE_CYCLES - 1);

  logic [3:0] state;
  logic [3:0] state_next;
  logic [2:0] rst_cnt;
  logic       illegal_q;
  logic [6:0] opcode;
  logic [1:0] imm_src;
  ctrl_t      ctrl;
  logic       unused_instr;

  assign opcode = bus.INSTR[6:0];

  // Only the opcode is consumed here; funct fields go to the ALU decoder
  assign unused_instr = ^bus.INSTR[XLEN-1:7];

  imm_src_dec u_imm_src_dec (
    .opcode  (opcode),
    .imm_src (imm_src)
  );

  // State register; reset aborts any instruction in flight
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_RESET;
    else      state <= state_next;
  end

  // Post-reset hold counter, reloaded on every reset
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                                        rst_cnt <= RST_LOAD;
    else if (state == S_RESET && rst_cnt != 3'd0)    rst_cnt <= rst_cnt - 3'd1;
  end

  // ILLEGAL: one-cycle pulse after a bad decode, or held while trapped
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) illegal_q <= 1'b0;
    else      illegal_q <= (state == S_TRAP) ||
                           (state == S_DECODE && !is_supported(opcode));
  end

  // Next-state logic; memory states wait on MEM_RDY
  always_comb begin
    state_next = state;
    case (state)
      S_RESET:    if (rst_cnt == 3'd0) state_next = S_FETCH;
      S_FETCH:    if (bus.MEM_RDY) state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECR;
          OP_I:         state_next = S_EXECI;
          OP_BEQ:       state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
`ifdef ILLEGAL_TRAP_EN
          default:      state_next = S_TRAP;
`else
          default:      state_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_next = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (bus.MEM_RDY) state_next = S_MEMWB;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: if (bus.MEM_RDY) state_next = S_FETCH;
      S_EXECR:    state_next = S_ALUWB;
      S_EXECI:    state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_BEQ:      state_next = S_FETCH;
      S_JAL:      state_next = S_ALUWB;
      S_TRAP:     state_next = S_TRAP;
      default:    state_next = S_RESET;
    endcase
  end

  // Control outputs: Moore per state, except PC_W/IR_W follow MEM_RDY in
  // fetch and PC_W follows ZERO in the branch state
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_req    = 1'b1;
        ctrl.adr_src    = ADR_PC;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALU_OP_ADD;
        ctrl.result_src = RES_ALURESULT;
        ctrl.ir_w       = bus.MEM_RDY;
        ctrl.pc_w       = bus.MEM_RDY;
      end
      S_DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRCA_RD1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      S_MEMREAD: begin
        ctrl.mem_req = 1'b1;
        ctrl.adr_src = ADR_ALUOUT;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_w      = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.mem_req = 1'b1;
        ctrl.adr_src = ADR_ALUOUT;
        ctrl.mem_w   = 1'b1;
      end
      S_EXECR: begin
        ctrl.alu_src_a = SRCA_RD1;
        ctrl.alu_src_b = SRCB_RD2;
        ctrl.alu_op    = ALU_OP_FUNCT;
      end
      S_EXECI: begin
        ctrl.alu_src_a = SRCA_RD1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_OP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_w      = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a  = SRCA_RD1;
        ctrl.alu_src_b  = SRCB_RD2;
        ctrl.alu_op     = ALU_OP_SUB;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_w       = bus.ZERO;
      end
      S_JAL: begin
        ctrl.alu_src_a  = SRCA_OLDPC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALU_OP_ADD;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_w       = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

  assign bus.MEM_REQ    = ctrl.mem_req;
  assign bus.MEM_W      = ctrl.mem_w;
  assign bus.PC_W       = ctrl.pc_w;
  assign bus.IR_W       = ctrl.ir_w;
  assign bus.REG_W      = ctrl.reg_w;
  assign bus.ADR_SRC    = ctrl.adr_src;
  assign bus.ALU_SRC_A  = ctrl.alu_src_a;
  assign bus.ALU_SRC_B  = ctrl.alu_src_b;
  assign bus.RESULT_SRC = ctrl.result_src;
  assign bus.ALU_OP     = ctrl.alu_op;
  assign bus.IMM_SRC    = imm_src;
  assign bus.ILLEGAL    = illegal_q;
  assign state_dbg      = state;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb_multi_cycle_ctrl: directed, table-driven bench for multi_cycle_ctrl.
// One table row per clock cycle: inputs applied just after the rising edge,
// state and outputs compared on the falling edge.
module tb_multi_cycle_ctrl;
  import riscv_ctrl_pkg::*;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_LW   = 32'h00802283;
  localparam logic [31:0] I_SW   = 32'h00502223;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_JAL  = 32'h008000EF;
  localparam logic [31:0] I_ADDI = 32'h00108093;
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  typedef struct {
    logic [31:0] instr;
    logic        zero;
    logic        rdy;
    logic [3:0]  st;
    logic [16:0] out;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       rst_n;
  logic [3:0] state_dbg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  multi_cycle_ctrl_if #(.XLEN(32)) bus ();

  multi_cycle_ctrl #(.XLEN(32), .RST_STATE_CYCLES(1)) dut (
    .CLK       (clk),
    .RST       (rst_n),
    .bus       (bus.master),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int   checks = 0;
  int   passes = 0;
  vec_t tbl[$];

  // Expected output word: {MEM_REQ, MEM_W, PC_W, IR_W, REG_W, ADR_SRC,
  // ALU_SRC_A, ALU_SRC_B, RESULT_SRC, ALU_OP, IMM_SRC, ILLEGAL}
  function automatic logic [16:0] o(input logic req, input logic w,
                                    input logic pcw, input logic irw,
                                    input logic regw, input logic adr,
                                    input logic [1:0] a, input logic [1:0] b,
                                    input logic [1:0] res, input logic [1:0] op,
                                    input logic [1:0] imm, input logic ill);
    return {req, w, pcw, irw, regw, adr, a, b, res, op, imm, ill};
  endfunction

  task automatic check(input string name, input logic [3:0] exp_st,
                       input logic [16:0] exp_out);
    logic [16:0] got;
    got = {bus.MEM_REQ, bus.MEM_W, bus.PC_W, bus.IR_W, bus.REG_W, bus.ADR_SRC,
           bus.ALU_SRC_A, bus.ALU_SRC_B, bus.RESULT_SRC, bus.ALU_OP,
           bus.IMM_SRC, bus.ILLEGAL};
    checks++;
    if (got === exp_out && state_dbg === exp_st) passes++;
    else $display("FAIL %s: got state=%0d out=%05h, expected state=%0d out=%05h",
                  name, state_dbg, got, exp_st, exp_out);
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge: drive, check on falling edge, advance
  task automatic step(input string name, input logic [31:0] instr,
                      input logic zero, input logic rdy,
                      input logic [3:0] st, input logic [16:0] ex);
    bus.INSTR   = instr;
    bus.ZERO    = zero;
    bus.MEM_RDY = rdy;
    @(negedge clk);
    check(name, st, ex);
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic [31:0] instr, input logic zero,
                         input logic rdy, input logic [3:0] st,
                         input logic [16:0] out);
    vec_t v;
    v.instr = instr; v.zero = zero; v.rdy = rdy; v.st = st; v.out = out;
    tbl.push_back(v);
  endtask

  // ---------------- test ----------------
  initial begin
    // add x3,x1,x2 : fetch, decode, execR, ALU write-back
    add_vec(I_ADD, 0, 1, S_FETCH,    o(1,0,1,1,0,0, 2'b00,2'b10,2'b10,2'b00, 2'b00,0));
    add_vec(I_ADD, 0, 1, S_DECODE,   o(0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 2'b00,0));
    add_vec(I_ADD, 0, 1, S_EXECR,    o(0,0,0,0,0,0, 2'b10,2'b00,2'b00,2'b10, 2'b00,0));
    add_vec(I_ADD, 0, 1, S_ALUWB,    o(0,0,0,0,1,0, 2'b00,2'b00,2'b00,2'b00, 2'b00,0));
    // lw x5,8(x0) with 3 read wait cycles: 8 cycles total
    add_vec(I_LW,  0, 1, S_FETCH,    o(1,0,1,1,0,0, 2'b00,2'b10,2'b10,2'b00, 2'b00,0));
    add_vec(I_LW,  0, 1, S_DECODE,   o(0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 2'b00,0));
    add_vec(I_LW,  0, 1, S_MEMADR,   o(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 2'b00,0));
    add_vec(I_LW,  0, 0, S_MEMREAD,  o(1,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 2'b00,0));
    add_vec(I_LW,  0, 0, S_MEMREAD,  o(1,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 2'b00,0));
    add_vec(I_LW,  0, 0, S_MEMREAD,  o(1,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 2'b00,0));
    add_vec(I_LW,  0, 1, S_MEMREAD,  o(1,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 2'b00,0));
    add_vec(I_LW,  0, 1, S_MEMWB,    o(0,0,0,0,1,0, 2'b00,2'b00,2'b01,2'b00, 2'b00,0));
    // sw x5,4(x0) with 2 fetch waits and 1 write wait
    add_vec(I_SW,  0, 0, S_FETCH,    o(1,0,0,0,0,0, 2'b00,2'b10,2'b10,2'b00, 2'b01,0));
    add_vec(I_SW,  0, 0, S_FETCH,    o(1,0,0,0,0,0, 2'b00,2'b10,2'b10,2'b00, 2'b01,0));
    add_vec(I_SW,  0, 1, S_FETCH,    o(1,0,1,1,0,0, 2'b00,2'b10,2'b10,2'b00, 2'b01,0));
    add_vec(I_SW,  0, 1, S_DECODE,   o(0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 2'b01,0));
    add_vec(I_SW,  0, 1, S_MEMADR,   o(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 2'b01,0));
    add_vec(I_SW,  0, 0, S_MEMWRITE, o(1,1,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 2'b01,0));
    add_vec(I_SW,  0, 1, S_MEMWRITE, o(1,1,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 2'b01,0));
    // beq taken (ZERO=1)
    add_vec(I_BEQ, 1, 1, S_FETCH,    o(1,0,1,1,0,0, 2'b00,2'b10,2'b10,2'b00, 2'b10,0));
    add_vec(I_BEQ, 1, 1, S_DECODE,   o(0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 2'b10,0));
    add_vec(I_BEQ, 1, 1, S_BEQ,      o(0,0,1,0,0,0, 2'b10,2'b00,2'b00,2'b01, 2'b10,0));
    // beq not taken (ZERO=0)
    add_vec(I_BEQ, 0, 1, S_FETCH,    o(1,0,1,1,0,0, 2'b00,2'b10,2'b10,2'b00, 2'b10,0));
    add_vec(I_BEQ, 0, 1, S_DECODE,   o(0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 2'b10,0));
    add_vec(I_BEQ, 0, 1, S_BEQ,      o(0,0,0,0,0,0, 2'b10,2'b00,2'b00,2'b01, 2'b10,0));
    // jal x1,8
    add_vec(I_JAL, 0, 1, S_FETCH,    o(1,0,1,1,0,0, 2'b00,2'b10,2'b10,2'b00, 2'b11,0));
    add_vec(I_JAL, 0, 1, S_DECODE,   o(0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 2'b11,0));
    add_vec(I_JAL, 0, 1, S_JAL,      o(0,0,1,0,0,0, 2'b01,2'b10,2'b00,2'b00, 2'b11,0));
    add_vec(I_JAL, 0, 1, S_ALUWB,    o(0,0,0,0,1,0, 2'b00,2'b00,2'b00,2'b00, 2'b11,0));
    // addi x1,x1,1
    add_vec(I_ADDI,0, 1, S_FETCH,    o(1,0,1,1,0,0, 2'b00,2'b10,2'b10,2'b00, 2'b00,0));
    add_vec(I_ADDI,0, 1, S_DECODE,   o(0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 2'b00,0));
    add_vec(I_ADDI,0, 1, S_EXECI,    o(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b10, 2'b00,0));
    add_vec(I_ADDI,0, 1, S_ALUWB,    o(0,0,0,0,1,0, 2'b00,2'b00,2'b00,2'b00, 2'b00,0));

    // Reset: everything idle, then exactly one idle cycle after release
    rst_n       = 1'b0;
    bus.INSTR   = '0;
    bus.ZERO    = 1'b0;
    bus.MEM_RDY = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_state", S_RESET, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("post_reset_idle", '0, 0, 1, S_RESET, '0);

    // Table of per-cycle vectors
    for (int i = 0; i < tbl.size(); i++)
      step($sformatf("vec%0d", i), tbl[i].instr, tbl[i].zero, tbl[i].rdy,
           tbl[i].st, tbl[i].out);

    // Reset asserted in the middle of S_MEMREAD with MEM_RDY high
    step("mr_fetch",  I_LW, 0, 1, S_FETCH,  o(1,0,1,1,0,0, 2'b00,2'b10,2'b10,2'b00, 2'b00,0));
    step("mr_decode", I_LW, 0, 1, S_DECODE, o(0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 2'b00,0));
    step("mr_memadr", I_LW, 0, 1, S_MEMADR, o(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 2'b00,0));
    bus.MEM_RDY = 1'b1;
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    check("mr_reset_abort", S_RESET, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("mr_idle",    I_LW, 0, 1, S_RESET,   '0);
    step("mr_refetch", I_LW, 0, 1, S_FETCH,   o(1,0,1,1,0,0, 2'b00,2'b10,2'b10,2'b00, 2'b00,0));
    step("mr_decode2", I_LW, 0, 1, S_DECODE,  o(0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 2'b00,0));
    step("mr_memadr2", I_LW, 0, 1, S_MEMADR,  o(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 2'b00,0));
    step("mr_memread", I_LW, 0, 1, S_MEMREAD, o(1,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 2'b00,0));
    step("mr_memwb",   I_LW, 0, 1, S_MEMWB,   o(0,0,0,0,1,0, 2'b00,2'b00,2'b01,2'b00, 2'b00,0));

    // Unsupported opcode
    step("ill_fetch",  I_BAD, 0, 1, S_FETCH,  o(1,0,1,1,0,0, 2'b00,2'b10,2'b10,2'b00, 2'b00,0));
    step("ill_decode", I_BAD, 0, 1, S_DECODE, o(0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 2'b00,0));
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 20; i++)
      step($sformatf("trap%0d", i), I_BAD, 1, 1, S_TRAP, o(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 2'b00,1));
`else
    step("ill_pulse",  I_BAD, 0, 0, S_FETCH, o(1,0,0,0,0,0, 2'b00,2'b10,2'b10,2'b00, 2'b00,1));
    step("ill_clear",  I_BAD, 0, 0, S_FETCH, o(1,0,0,0,0,0, 2'b00,2'b10,2'b10,2'b00, 2'b00,0));
`endif

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
